max7219_spi_rx: RTL and testbench

Receive-side model of a daisy-chained MAX7219 display string. Deserialises the three-wire SPI stream (STB/CLK/DIN) in the i_Clk domain and decodes one 16-bit command word per device. Holds a per-device register image: row data plus the shutdown, test, intensity, scan-limit and decode registers. Used as a loopback checker and display emulator behind the MAX7219 SPI transmitter, and exposes the image through a registered read port.

---
 rtl/max7219_spi_rx.sv | 200 ++++++++++++++++++++
 tb/tb_max7219_spi_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_spi_rx.sv
// Receive-side model of a daisy-chained MAX7219 string: deserialises STB/CLK/DIN in the
// i_Clk domain and maintains the per-device register image behind a registered read port.
module max7219_spi_rx #(
  parameter int unsigned NUM_DEVICES = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_SPI_Stb,
  input  logic                           i_SPI_Clk,
  input  logic                           i_SPI_Din,
  input  logic [$clog2(NUM_DEVICES)-1:0] i_Rd_Dev,
  input  logic [2:0]                     i_Rd_Row,
  output logic [7:0]                     o_Rd_Data,
  output logic [NUM_DEVICES-1:0]         o_Shutdown,
  output logic [NUM_DEVICES-1:0]         o_Test,
  output logic [3:0]                     o_Intensity,
  output logic [2:0]                     o_Scan_Limit,
  output logic [7:0]                     o_Decode,
  output logic                           o_Frame_Valid,
  output logic                           o_Frame_Error,
  output logic [15:0]                    o_Frame_Count
);

  localparam int unsigned FrameBits = NUM_DEVICES * 16;
  // The top bit of the most distant word is never decoded, so it is not stored.
  localparam int unsigned ShiftW    = FrameBits - 1;
  localparam int unsigned CntW      = $clog2(FrameBits + 2);
  localparam int unsigned DevW      = $clog2(NUM_DEVICES);
  localparam logic [CntW-1:0] CntFull = CntW'(FrameBits);
  localparam logic [CntW-1:0] CntSat  = CntW'(FrameBits + 1);
  localparam logic [DevW:0]   NumDevL = (DevW + 1)'(NUM_DEVICES);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  logic [SYNC_STAGES-1:0] stb_sync_q, clk_sync_q, din_sync_q;
  logic                   stb_dly_q, clk_dly_q;
  logic                   stb_s, clk_s, din_s;
  logic                   stb_fall, stb_rise, clk_rise;

  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign stb_fall = stb_dly_q & ~stb_s;
  assign stb_rise = ~stb_dly_q & stb_s;
  assign clk_rise = ~clk_dly_q & clk_s;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      stb_sync_q <= '1;
      clk_sync_q <= '0;
      din_sync_q <= '0;
      stb_dly_q  <= 1'b1;
      clk_dly_q  <= 1'b0;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], i_SPI_Stb};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], i_SPI_Din};
      stb_dly_q  <= stb_s;
      clk_dly_q  <= clk_s;
    end
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ShiftW-1:0] shift_q, shift_d;
  logic              commit_ok, commit_bad;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (stb_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          if (clk_rise) begin
            shift_d = {shift_q[ShiftW-2:0], din_s};
            cnt_d   = CntW'(1);
          end
        end
      end
      StShift: begin
        if (clk_rise) begin
          shift_d = {shift_q[ShiftW-2:0], din_s};
          if (cnt_q != CntSat) cnt_d = cnt_q + CntW'(1);
        end
        if (stb_rise) state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
        if (cnt_q == CntFull) commit_ok = 1'b1;
        else                  commit_bad = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  logic [NUM_DEVICES-1:0][7:0][7:0] rows_q, rows_d;
  logic [NUM_DEVICES-1:0]           shutdown_q, shutdown_d;
  logic [NUM_DEVICES-1:0]           test_q, test_d;
  logic [NUM_DEVICES-1:0][3:0]      intensity_q, intensity_d;
  logic [NUM_DEVICES-1:0][2:0]      scan_q, scan_d;
  logic [NUM_DEVICES-1:0][7:0]      decode_q, decode_d;

  always_comb begin
    logic [3:0] addr;
    logic [7:0] data;
    rows_d      = rows_q;
    shutdown_d  = shutdown_q;
    test_d      = test_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    decode_d    = decode_q;
    addr        = '0;
    data        = '0;
    if (commit_ok) begin
      for (int unsigned k = 0; k < NUM_DEVICES; k++) begin
        addr = shift_q[16*k+8 +: 4];
        data = shift_q[16*k +: 8];
        case (addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: rows_d[k][3'(addr - 4'd1)] = data;
          4'h9:    decode_d[k]    = data;
          4'hA:    intensity_d[k] = data[3:0];
          4'hB:    scan_d[k]      = data[2:0];
          4'hC:    shutdown_d[k]  = ~data[0];
          4'hF:    test_d[k]      = data[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rows_q        <= '0;
      shutdown_q    <= '1;
      test_q        <= '0;
      intensity_q   <= '0;
      scan_q        <= '0;
      decode_q      <= '0;
      o_Frame_Valid <= 1'b0;
      o_Frame_Error <= 1'b0;
      o_Frame_Count <= '0;
    end else begin
      rows_q        <= rows_d;
      shutdown_q    <= shutdown_d;
      test_q        <= test_d;
      intensity_q   <= intensity_d;
      scan_q        <= scan_d;
      decode_q      <= decode_d;
      o_Frame_Valid <= commit_ok;
      o_Frame_Error <= commit_bad;
      if (commit_ok) o_Frame_Count <= o_Frame_Count + 16'd1;
    end
  end

  assign o_Shutdown = shutdown_q;
  assign o_Test     = test_q;

  logic dev_ok;
  assign dev_ok = {1'b0, i_Rd_Dev} < NumDevL;

  // Sampling the pre-update image gives commit-cycle reads their old value.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Rd_Data    <= '0;
      o_Intensity  <= '0;
      o_Scan_Limit <= '0;
      o_Decode     <= '0;
    end else if (dev_ok) begin
      o_Rd_Data    <= rows_q[i_Rd_Dev][i_Rd_Row];
      o_Intensity  <= intensity_q[i_Rd_Dev];
      o_Scan_Limit <= scan_q[i_Rd_Dev];
      o_Decode     <= decode_q[i_Rd_Dev];
    end else begin
      o_Rd_Data    <= '0;
      o_Intensity  <= '0;
      o_Scan_Limit <= '0;
      o_Decode     <= '0;
    end
  end

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Directed self-checking bench for max7219_spi_rx: frames driven bit by bit on the SPI pins,
// register image checked through the read port.
module tb_max7219_spi_rx;

  localparam int ND = 20;
  localparam int FB = ND * 16;

  logic          clk = 1'b0;
  logic          rst, stb, sclk, din;
  logic [4:0]    rd_dev;
  logic [2:0]    rd_row;
  logic [7:0]    rd_data, decode;
  logic [ND-1:0] shut, tst;
  logic [3:0]    inten;
  logic [2:0]    scan;
  logic          fr_valid, fr_err;
  logic [15:0]   fr_cnt;

  int checks = 0;
  int fails  = 0;

  max7219_spi_rx #(.NUM_DEVICES(ND), .SYNC_STAGES(2)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_SPI_Stb    (stb),
    .i_SPI_Clk    (sclk),
    .i_SPI_Din    (din),
    .i_Rd_Dev     (rd_dev),
    .i_Rd_Row     (rd_row),
    .o_Rd_Data    (rd_data),
    .o_Shutdown   (shut),
    .o_Test       (tst),
    .o_Intensity  (inten),
    .o_Scan_Limit (scan),
    .o_Decode     (decode),
    .o_Frame_Valid(fr_valid),
    .o_Frame_Error(fr_err),
    .o_Frame_Count(fr_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    din = b; sclk = 1'b0; cyc(4);
    sclk = 1'b1; cyc(4);
  endtask

  // Sends bits nbits-1..0 of f MSB first; positions >= FB are sent as zero.
  task automatic send_frame(input logic [FB-1:0] f, input int nbits, input bit same_edge);
    stb = 1'b0; cyc(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      logic b;
      b = (i < FB) ? f[i] : 1'b0;
      if (same_edge && i == 0) begin
        din = b; sclk = 1'b0; cyc(4);
        sclk = 1'b1; stb = 1'b1;
      end else begin
        spi_bit(b);
      end
    end
    if (!same_edge) begin
      sclk = 1'b0; cyc(4);
      stb = 1'b1;
    end
  endtask

  task automatic wait_frame(output bit v, output bit e, output int lat);
    v = 1'b0; e = 1'b0; lat = 0;
    for (int i = 1; i <= 16 && !v && !e; i++) begin
      @(negedge clk);
      if (fr_valid) begin v = 1'b1; lat = i; end
      if (fr_err)   begin e = 1'b1; lat = i; end
    end
  endtask

  task automatic rd(input int dev, input int row);
    rd_dev = dev[4:0]; rd_row = row[2:0]; cyc(1);
  endtask

  function automatic logic [FB-1:0] fill(input logic [15:0] w);
    logic [FB-1:0] f;
    for (int k = 0; k < ND; k++) f[16*k +: 16] = w;
    return f;
  endfunction

  task automatic test_reset;
    rst = 1'b1; stb = 1'b1; sclk = 1'b0; din = 1'b0; rd_dev = '0; rd_row = '0;
    cyc(3);
    rst = 1'b0; cyc(2);
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 8; r++) begin
        rd(d, r);
        checks++;
        if (rd_data !== 8'h00) begin
          fails++; $display("FAIL reset_row d%0d r%0d: got %h want 00", d, r, rd_data);
        end
      end
      checks++;
      if (inten !== 4'h0 || scan !== 3'h0 || decode !== 8'h00) begin
        fails++;
        $display("FAIL reset_cfg d%0d: got int %h scan %h dec %h want 0", d, inten, scan, decode);
      end
    end
    checks++;
    if (shut !== {ND{1'b1}}) begin fails++; $display("FAIL reset_shut: got %h", shut); end
    checks++;
    if (tst !== '0) begin fails++; $display("FAIL reset_test: got %h want 0", tst); end
    checks++;
    if (fr_cnt !== 16'd0 || fr_valid !== 1'b0 || fr_err !== 1'b0) begin
      fails++; $display("FAIL reset_frame: cnt %0d v %b e %b want 0", fr_cnt, fr_valid, fr_err);
    end
  endtask

  task automatic test_config;
    bit v, e; int lat;
    send_frame(fill(16'h0C01), FB, 1'b0);
    wait_frame(v, e, lat);
    checks++;
    if (!v || e || lat != 4) begin
      fails++; $display("FAIL cfg_frame1: v %b e %b lat %0d want 1 0 4", v, e, lat);
    end
    cyc(4);
    send_frame(fill(16'h0A07), FB, 1'b0);
    wait_frame(v, e, lat);
    checks++;
    if (!v || e) begin fails++; $display("FAIL cfg_frame2: v %b e %b want 1 0", v, e); end
    cyc(2);
    checks++;
    if (shut !== '0) begin fails++; $display("FAIL cfg_shut: got %h want 0", shut); end
    checks++;
    if (fr_cnt !== 16'd2) begin fails++; $display("FAIL cfg_count: got %0d want 2", fr_cnt); end
    for (int d = 0; d < ND; d++) begin
      rd(d, 0);
      checks++;
      if (inten !== 4'h7) begin fails++; $display("FAIL cfg_int d%0d: got %h want 7", d, inten); end
    end
    rd(25, 0);
    checks++;
    if (inten !== 4'h0 || rd_data !== 8'h00) begin
      fails++; $display("FAIL cfg_oob: got int %h data %h want 0 00", inten, rd_data);
    end
  endtask

  task automatic test_rows;
    logic [FB-1:0] f; bit v, e; int lat;
    f = '0;
    f[16*19 +: 16] = 16'h0181;
    f[0 +: 16]     = 16'h0818;
    send_frame(f, FB, 1'b0);
    wait_frame(v, e, lat);
    checks++;
    if (!v || e) begin fails++; $display("FAIL rows_frame: v %b e %b want 1 0", v, e); end
    cyc(2);
    checks++;
    if (fr_cnt !== 16'd3) begin fails++; $display("FAIL rows_count: got %0d want 3", fr_cnt); end
    rd(19, 0); checks++;
    if (rd_data !== 8'h81) begin fails++; $display("FAIL rows_d19r0: got %h want 81", rd_data); end
    rd(0, 7); checks++;
    if (rd_data !== 8'h18) begin fails++; $display("FAIL rows_d0r7: got %h want 18", rd_data); end
    rd(19, 7); checks++;
    if (rd_data !== 8'h00) begin fails++; $display("FAIL rows_d19r7: got %h want 00", rd_data); end
    rd(0, 0); checks++;
    if (rd_data !== 8'h00) begin fails++; $display("FAIL rows_d0r0: got %h want 00", rd_data); end
    rd(5, 0); checks++;
    if (rd_data !== 8'h00 || inten !== 4'h7) begin
      fails++; $display("FAIL rows_d5: got %h int %h want 00 7", rd_data, inten);
    end
  endtask

  task automatic test_misc_regs;
    logic [FB-1:0] f; bit v, e; int lat;
    f = '0;
    f[16*1 +: 16] = 16'h0B05;
    f[16*2 +: 16] = 16'h0903;
    f[16*4 +: 16] = 16'h0F01;
    f[16*5 +: 16] = 16'h0C00;
    f[16*6 +: 16] = 16'h0D55;
    f[16*7 +: 16] = 16'hF0FF;
    send_frame(f, FB, 1'b0);
    wait_frame(v, e, lat);
    checks++;
    if (!v || e) begin fails++; $display("FAIL misc_frame: v %b e %b want 1 0", v, e); end
    cyc(2);
    checks++;
    if (tst !== 20'h00010) begin fails++; $display("FAIL misc_test: got %h want 00010", tst); end
    checks++;
    if (shut !== 20'h00020) begin fails++; $display("FAIL misc_shut: got %h want 00020", shut); end
    rd(1, 0); checks++;
    if (scan !== 3'd5) begin fails++; $display("FAIL misc_scan: got %0d want 5", scan); end
    rd(2, 0); checks++;
    if (decode !== 8'h03) begin fails++; $display("FAIL misc_decode: got %h want 03", decode); end
    rd(6, 0); checks++;
    if (inten !== 4'h7 || rd_data !== 8'h00 || decode !== 8'h00) begin
      fails++; $display("FAIL misc_ignored: int %h data %h dec %h", inten, rd_data, decode);
    end
    rd(7, 0); checks++;
    if (rd_data !== 8'h00 || decode !== 8'h00 || inten !== 4'h7) begin
      fails++; $display("FAIL misc_noop: data %h dec %h int %h", rd_data, decode, inten);
    end
    rd(19, 0); checks++;
    if (rd_data !== 8'h81) begin fails++; $display("FAIL misc_keep: got %h want 81", rd_data); end
  endtask

  task automatic test_bad_length;
    bit v, e; int lat;
    send_frame(fill(16'h01FF), FB - 1, 1'b0);
    wait_frame(v, e, lat);
    checks++;
    if (v || !e) begin fails++; $display("FAIL short_frame: v %b e %b want 0 1", v, e); end
    cyc(4);
    send_frame(fill(16'h01FF), FB + 1, 1'b0);
    wait_frame(v, e, lat);
    checks++;
    if (v || !e) begin fails++; $display("FAIL long_frame: v %b e %b want 0 1", v, e); end
    cyc(2);
    checks++;
    if (fr_cnt !== 16'd4) begin fails++; $display("FAIL bad_count: got %0d want 4", fr_cnt); end
    rd(19, 0); checks++;
    if (rd_data !== 8'h81) begin fails++; $display("FAIL bad_d19r0: got %h want 81", rd_data); end
    rd(3, 0); checks++;
    if (rd_data !== 8'h00) begin fails++; $display("FAIL bad_d3r0: got %h want 00", rd_data); end
  endtask

  task automatic test_reset_midframe;
    bit v, e; int lat;
    stb = 1'b0; cyc(4);
    for (int i = 0; i < 100; i++) spi_bit(i[0]);
    sclk = 1'b0; rst = 1'b1; cyc(2);
    checks++;
    if (shut !== {ND{1'b1}} || fr_cnt !== 16'd0 || tst !== '0) begin
      fails++; $display("FAIL mid_reset: shut %h cnt %0d test %h", shut, fr_cnt, tst);
    end
    rst = 1'b0; cyc(1);
    rd(19, 0); checks++;
    if (rd_data !== 8'h00) begin fails++; $display("FAIL mid_row: got %h want 00", rd_data); end
    rd(0, 0); checks++;
    if (inten !== 4'h0) begin fails++; $display("FAIL mid_int: got %h want 0", inten); end
    rd(1, 0); checks++;
    if (scan !== 3'd0) begin fails++; $display("FAIL mid_scan: got %0d want 0", scan); end
    // STB is still low after release, so a truncated frame must end in an error.
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    sclk = 1'b0; cyc(4); stb = 1'b1;
    wait_frame(v, e, lat);
    checks++;
    if (v || !e) begin fails++; $display("FAIL mid_trunc: v %b e %b want 0 1", v, e); end
    cyc(4);
    send_frame(fill(16'h0155), FB, 1'b0);
    wait_frame(v, e, lat);
    checks++;
    if (!v || e) begin fails++; $display("FAIL mid_next: v %b e %b want 1 0", v, e); end
    cyc(2);
    checks++;
    if (fr_cnt !== 16'd1) begin fails++; $display("FAIL mid_count: got %0d want 1", fr_cnt); end
    rd(10, 0); checks++;
    if (rd_data !== 8'h55) begin fails++; $display("FAIL mid_d10r0: got %h want 55", rd_data); end
  endtask

  task automatic test_same_edge;
    logic [FB-1:0] f; bit v, e; int lat;
    f = '0;
    f[16*3 +: 16] = 16'h01A5;
    f[0 +: 16]    = 16'h0103;
    rd_dev = 5'd3; rd_row = 3'd0;
    send_frame(f, FB, 1'b1);
    wait_frame(v, e, lat);
    checks++;
    if (!v || e || lat != 4) begin
      fails++; $display("FAIL edge_frame: v %b e %b lat %0d want 1 0 4", v, e, lat);
    end
    checks++;
    if (rd_data !== 8'h55) begin fails++; $display("FAIL edge_commit_rd: got %h want 55", rd_data); end
    cyc(1);
    checks++;
    if (rd_data !== 8'hA5) begin fails++; $display("FAIL edge_next_rd: got %h want a5", rd_data); end
    checks++;
    if (fr_cnt !== 16'd2) begin fails++; $display("FAIL edge_count: got %0d want 2", fr_cnt); end
    rd(0, 0); checks++;
    if (rd_data !== 8'h03) begin fails++; $display("FAIL edge_d0r0: got %h want 03", rd_data); end
  endtask

  initial begin
    test_reset;
    test_config;
    test_rows;
    test_misc_regs;
    test_bad_length;
    test_reset_midframe;
    test_same_edge;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
